eth_tx_fcs_ctrl: RTL and testbench

Transmit-side frame sequencer for the byte-wide (GMII) Ethernet MAC. It accepts a payload stream over a valid/ready handshake and emits a complete GMII frame: preamble, SFD, payload, zero padding to the minimum length, a 4-byte FCS and the inter-frame gap. It owns the CRC-32 engine: it initialises the engine, feeds it one byte per cycle over payload and pad bytes, and serialises the complemented remainder. It sits between the TX FIFO and the GMII pins.

---
 rtl/eth_pkg.sv | 32 +++
 rtl/eth_tx_fcs_ctrl_if.sv | 35 +++
 rtl/crc32_byte_step.sv | 28 ++
 rtl/eth_tx_fcs_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_eth_tx_fcs_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_pkg
// Description : Shared constants and types for the GMII transmit path:
//               preamble/SFD symbols, reflected CRC-32 constants, default
//               frame sizing and the transmit sequencer state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  localparam int          ETH_MIN_PAYLOAD = 60;
  localparam int          ETH_IFG         = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_PAD      = 3'd4,
    ST_FCS      = 3'd5,
    ST_IFG      = 3'd6,
    ST_DRAIN    = 3'd7
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/eth_tx_fcs_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_fcs_ctrl_if
// Description : Bundles the payload stream (valid/ready byte handshake) and
//               the GMII transmit pins of the frame sequencer.
//               master : payload source / GMII observer (FIFO side + PHY)
//               slave  : the frame sequencer itself
//   s_data[7:0]   payload byte          gmii_txd[7:0] transmit data
//   s_valid       s_data valid          gmii_tx_en    transmit enable
//   s_last        final payload byte    gmii_tx_er    transmit error
//   s_ready       byte accepted when s_valid && s_ready
// Revision    : 1.0 - initial release
// ============================================================================
interface eth_tx_fcs_ctrl_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;

  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, gmii_txd, gmii_tx_en, gmii_tx_er
  );

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, gmii_txd, gmii_tx_en, gmii_tx_er
  );

endinterface
`default_nettype wire

// File: rtl/crc32_byte_step.sv
`default_nettype none
// ============================================================================
// Module      : crc32_byte_step
// Description : One byte of reflected CRC-32 (poly 0xEDB88320), data bits
//               consumed LSB first. Purely combinational; the caller owns
//               the CRC register.
//   crc_in[31:0]  current remainder
//   data[7:0]     byte to fold in
//   crc_out[31:0] remainder after the byte
// Revision    : 1.0 - initial release
// ============================================================================
module crc32_byte_step
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY_REFL) : (crc_out >> 1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_tx_fcs_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_fcs_ctrl
// Description : GMII transmit frame sequencer. Wraps a payload stream with
//               preamble/SFD, pads short frames with zeros, appends the
//               complemented CRC-32 FCS and enforces the inter-frame gap.
//               Underflow mid-payload emits a single tx_er cycle and drains
//               the rest of the frame without transmitting it.
//   clk, rst      clock, synchronous active-high reset
//   tx            stream + GMII bundle (slave side)
//   cfg_pad_en    pad short frames (sampled at frame start)
//   busy          sequencer not idle
//   frame_cnt     completed frames, wraps at 0xFFFF
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_fcs_ctrl
  import eth_pkg::*;
#(
  parameter int MIN_PAYLOAD = ETH_MIN_PAYLOAD,
  parameter int IFG_CYCLES  = ETH_IFG
) (
  input  logic               clk,
  input  logic               rst,
  eth_tx_fcs_ctrl_if.slave   tx,
  input  logic               cfg_pad_en,
  output logic               busy,
  output logic [15:0]        frame_cnt
);

  localparam logic [12:0] C_MIN_LEN  = 13'(MIN_PAYLOAD);
  localparam logic [15:0] C_IFG_LAST = 16'(IFG_CYCLES - 1);
  localparam logic [15:0] C_PRE_LAST = 16'd6;

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;           // preamble / FCS / IFG position
  logic [11:0] byte_cnt_q, byte_cnt_d; // payload + pad bytes, saturating
  logic [31:0] crc_q, crc_d;
  logic        pad_en_q, pad_en_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic [7:0]  w_step_data;
  logic [31:0] w_crc_next;
  logic [11:0] w_byte_cnt_inc;
  logic [7:0]  w_fcs_byte;

  // Pad bytes are zeros; everything else folded into the CRC is the
  // payload byte being accepted this cycle.
  assign w_step_data = (state_q == ST_PAD) ? 8'h00 : tx.s_data;

  crc32_byte_step u_crc_step (
    .crc_in  (crc_q),
    .data    (w_step_data),
    .crc_out (w_crc_next)
  );

  assign w_byte_cnt_inc = (byte_cnt_q == 12'hFFF) ? byte_cnt_q : byte_cnt_q + 12'd1;

  always_comb begin
    w_fcs_byte = 8'h00;
    case (cnt_q[1:0])
      2'd0:    w_fcs_byte = ~crc_q[7:0];
      2'd1:    w_fcs_byte = ~crc_q[15:8];
      2'd2:    w_fcs_byte = ~crc_q[23:16];
      default: w_fcs_byte = ~crc_q[31:24];
    endcase
  end

  // Outputs are registered, so each state computes what goes on the pins
  // in the following cycle. The SFD cycle already accepts the first payload
  // byte so that it lands on txd directly behind the SFD.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    pad_en_d    = pad_en_q;
    txd_d       = 8'h00;
    tx_en_d     = 1'b0;
    tx_er_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (tx.s_valid) begin
          pad_en_d   = cfg_pad_en;
          crc_d      = CRC32_INIT;
          byte_cnt_d = 12'd0;
          cnt_d      = 16'd0;
          txd_d      = ETH_PREAMBLE;
          tx_en_d    = 1'b1;
          state_d    = ST_PREAMBLE;
        end
      end

      ST_PREAMBLE: begin
        tx_en_d = 1'b1;
        if (cnt_q == C_PRE_LAST) begin
          txd_d   = ETH_SFD;
          state_d = ST_SFD;
        end else begin
          txd_d = ETH_PREAMBLE;
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_SFD, ST_PAYLOAD: begin
        tx_en_d = 1'b1;
        if (tx.s_valid) begin
          txd_d      = tx.s_data;
          crc_d      = w_crc_next;
          byte_cnt_d = w_byte_cnt_inc;
          state_d    = ST_PAYLOAD;
          if (tx.s_last) begin
            cnt_d = 16'd0;
            if (pad_en_q && (({1'b0, byte_cnt_q} + 13'd1) < C_MIN_LEN)) begin
              state_d = ST_PAD;
            end else begin
              state_d = ST_FCS;
            end
          end
        end else begin
          // Source ran dry mid-frame: poison the frame on the wire.
          tx_er_d = 1'b1;
          txd_d   = 8'h00;
          state_d = ST_DRAIN;
        end
      end

      ST_PAD: begin
        tx_en_d    = 1'b1;
        txd_d      = 8'h00;
        crc_d      = w_crc_next;
        byte_cnt_d = w_byte_cnt_inc;
        if ({1'b0, w_byte_cnt_inc} >= C_MIN_LEN) begin
          cnt_d   = 16'd0;
          state_d = ST_FCS;
        end
      end

      ST_FCS: begin
        tx_en_d = 1'b1;
        txd_d   = w_fcs_byte;
        if (cnt_q[1:0] == 2'd3) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          cnt_d       = 16'd0;
          state_d     = ST_IFG;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // The first IFG cycle still shows the last FCS byte; the IDLE cycle
      // that follows supplies the final low cycle of the gap.
      ST_IFG: begin
        if (cnt_q == C_IFG_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_DRAIN: begin
        if (tx.s_valid && tx.s_last) begin
          cnt_d   = 16'd0;
          state_d = ST_IFG;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      byte_cnt_q  <= 12'd0;
      crc_q       <= CRC32_INIT;
      pad_en_q    <= 1'b0;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      pad_en_q    <= pad_en_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= tx_er_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign tx.s_ready    = (state_q == ST_SFD) || (state_q == ST_PAYLOAD) ||
                         (state_q == ST_DRAIN);
  assign tx.gmii_txd   = txd_q;
  assign tx.gmii_tx_en = tx_en_q;
  assign tx.gmii_tx_er = tx_er_q;
  assign busy          = (state_q != ST_IDLE);
  assign frame_cnt     = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_fcs_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_tx_fcs_ctrl
// Description : Directed testbench for eth_tx_fcs_ctrl. A frame-level model
//               builds the expected GMII byte stream and frame lengths; a
//               monitor compares every tx_en cycle against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_fcs_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_pad_en;
  logic        busy;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  eth_tx_fcs_ctrl_if bus ();

  eth_tx_fcs_ctrl #(
    .MIN_PAYLOAD (60),
    .IFG_CYCLES  (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx         (bus.slave),
    .cfg_pad_en (cfg_pad_en),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  typedef struct {
    logic [7:0] d;
    logic       er;
  } ent_t;

  int   tests = 0;
  int   fails = 0;
  ent_t exp_q[$];
  int   len_q[$];
  logic [7:0] pl   [0:255];
  logic [7:0] body [0:4095];
  bit   ignore = 1'b0;
  int   run = 0, low_run = 0, last_run = 0, last_gap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference CRC-32 (reflected, init all-ones, final complement) over body[].
  function automatic logic [31:0] crc32_buf(input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      c = c ^ {24'h0, body[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push(input logic [7:0] d, input logic er);
    ent_t e;
    e.d  = d;
    e.er = er;
    exp_q.push_back(e);
  endtask

  // Expected wire image of one frame built from pl[0..n-1].
  // uf_at >= 0: source stalls after uf_at bytes -> error byte, nothing more.
  task automatic model_frame(input int n, input bit pad_en, input int uf_at);
    int blen;
    logic [31:0] f;
    for (int i = 0; i < 7; i++) push(8'h55, 1'b0);
    push(8'hD5, 1'b0);
    if (uf_at >= 0) begin
      for (int i = 0; i < uf_at; i++) push(pl[i], 1'b0);
      push(8'h00, 1'b1);
      len_q.push_back(8 + uf_at + 1);
    end else begin
      blen = n;
      for (int i = 0; i < n; i++) body[i] = pl[i];
      if (pad_en) while (blen < 60) begin body[blen] = 8'h00; blen++; end
      for (int i = 0; i < blen; i++) push(body[i], 1'b0);
      f = crc32_buf(blen);
      push(f[7:0], 1'b0);
      push(f[15:8], 1'b0);
      push(f[23:16], 1'b0);
      push(f[31:24], 1'b0);
      len_q.push_back(8 + blen + 4);
    end
  endtask

  // Monitor: compares every transmitted cycle and every frame length.
  always @(negedge clk) begin : mon
    ent_t e;
    if (ignore) begin
      run     = 0;
      low_run = 0;
    end else if (bus.gmii_tx_en) begin
      if (run == 0) last_gap = low_run;
      run++;
      if (exp_q.size() == 0) begin
        chk("tx_en_unexpected", 32'(bus.gmii_tx_en), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("txd", 32'(bus.gmii_txd), 32'(e.d));
        chk("tx_er", 32'(bus.gmii_tx_er), 32'(e.er));
      end
    end else begin
      chk("tx_er_idle", 32'(bus.gmii_tx_er), 32'd0);
      if (run > 0) begin
        last_run = run;
        if (len_q.size() > 0) chk("frame_len", run, len_q.pop_front());
        else                  chk("frame_len_unexpected", run, 0);
        low_run = 0;
      end
      low_run++;
      run = 0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_txd"},       32'(bus.gmii_txd),   32'd0);
    chk({tag, "_tx_en"},     32'(bus.gmii_tx_en), 32'd0);
    chk({tag, "_tx_er"},     32'(bus.gmii_tx_er), 32'd0);
    chk({tag, "_s_ready"},   32'(bus.s_ready),    32'd0);
    chk({tag, "_busy"},      32'(busy),           32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt),      32'd0);
  endtask

  // Drive pl[0..n-1]; optionally drop s_valid for one cycle after stall_at
  // bytes, or pulse rst after rst_at bytes and abandon the frame.
  task automatic send_frame(input int n, input int stall_at, input int rst_at);
    int k;
    int budget;
    bit acc;
    bit stall_done;
    k = 0;
    budget = 0;
    stall_done = 1'b0;
    while (k < n) begin
      if (k == rst_at) begin
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("rst_mid");
        return;
      end
      if (k == stall_at && !stall_done) begin
        bus.s_valid = 1'b0;
        stall_done  = 1'b1;
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = pl[k];
        bus.s_last  = (k == n - 1);
      end
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      budget++;
      if (budget > 2000) begin
        chk("send_timeout", k, n);
        return;
      end
    end
  endtask

  task automatic go_idle();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    cfg_pad_en  = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pin the reference CRC to the well-known check value.
    for (int i = 0; i < 9; i++) body[i] = 8'(8'h31 + i);
    chk("model_crc_123456789", crc32_buf(9), 32'hCBF43926);

    // 1: "123456789", no pad, literal expectations.
    for (int i = 0; i < 9; i++) pl[i] = 8'(8'h31 + i);
    for (int i = 0; i < 7; i++) push(8'h55, 1'b0);
    push(8'hD5, 1'b0);
    for (int i = 0; i < 9; i++) push(8'(8'h31 + i), 1'b0);
    push(8'h26, 1'b0); push(8'h39, 1'b0); push(8'hF4, 1'b0); push(8'hCB, 1'b0);
    len_q.push_back(21);
    send_frame(9, -1, -1);
    chk("busy_in_frame", 32'(busy), 32'd1);
    go_idle();
    chk("t1_len", last_run, 21);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);

    // 2: single byte with padding.
    cfg_pad_en = 1'b1;
    pl[0] = 8'hAA;
    model_frame(1, 1'b1, -1);
    send_frame(1, -1, -1);
    go_idle();
    chk("t2_len", last_run, 72);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);

    // 3: exactly 60 bytes with padding enabled -> no pad.
    for (int i = 0; i < 60; i++) pl[i] = 8'(i * 7 + 3);
    model_frame(60, 1'b1, -1);
    send_frame(60, -1, -1);
    go_idle();
    chk("t3_len", last_run, 72);
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd3);

    // 4: underflow after 5 bytes of a 10-byte frame.
    cfg_pad_en = 1'b0;
    for (int i = 0; i < 10; i++) pl[i] = 8'(8'hA0 + i);
    model_frame(10, 1'b0, 5);
    send_frame(10, 5, -1);
    go_idle();
    chk("t4_len", last_run, 14);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd3);

    // 5: reset during payload, then a clean frame.
    ignore = 1'b1;
    for (int i = 0; i < 20; i++) pl[i] = 8'(8'h10 + i);
    send_frame(20, -1, 8);
    ignore = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) pl[i] = 8'(8'h31 + i);
    model_frame(9, 1'b0, -1);
    send_frame(9, -1, -1);
    go_idle();
    chk("t5_len", last_run, 21);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd1);

    // 6: back-to-back frames with s_valid held, counter cleared first.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) pl[i] = 8'(8'hC0 + i);
    model_frame(4, 1'b0, -1);
    model_frame(4, 1'b0, -1);
    send_frame(4, -1, -1);
    send_frame(4, -1, -1);
    go_idle();
    chk("t6_gap", last_gap, 12);
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd2);

    chk("exp_leftover", exp_q.size(), 0);
    chk("len_leftover", len_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
